// File: rtl/raise_frame_buffer.sv
// Ping-pong 64-bin frame buffer between raiseFreq and the IFFT; replays each completed frame in bin order.
// Optional macro RAISE_FRAME_ZERO_FILL_EN: bins not written in a frame replay as zero instead of stale data.
module raise_frame_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_freq,
    input  logic              in_fin,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow
);

    localparam int unsigned       MEM_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] mem [2*DEPTH];
    logic              wbank;
    logic              pending;
    logic              beat;
    logic              frame_end;
    logic              read_free;
    logic              swap;
    logic              drop;
    logic              valid_d;
    logic              last_d;
    logic              load_data;
    logic [ADDR_W-1:0] idx_d;
    logic [ADDR_W-1:0] rd_idx;
    logic [MEM_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] data_d;

    assign beat      = out_valid & out_ready;
    assign frame_end = in_valid & in_fin;
    // Read bank is free when nothing is queued, or the last beat leaves this very cycle.
    assign read_free = ((state == S_IDLE) && !pending) ||
                       ((state == S_STREAM) && beat && (out_idx == LAST_IDX));
    assign swap      = frame_end & read_free;
    assign drop      = frame_end & ~read_free;

    // The read bank is always the one not being written.
    assign rd_addr = {~wbank, rd_idx};
    assign rd_word = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[{wbank, in_freq}] <= in_data;
        end
    end

`ifdef RAISE_FRAME_ZERO_FILL_EN
    logic [DEPTH-1:0] wr_mask;
    logic [DEPTH-1:0] rd_mask;
    logic [DEPTH-1:0] wr_mask_set;

    always_comb begin
        wr_mask_set = wr_mask;
        if (in_valid) begin
            wr_mask_set[in_freq] = 1'b1;
        end
    end

    // Written-bin mask follows the frame: handed to the reader on swap, discarded on drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_mask <= '0;
            rd_mask <= '0;
        end else if (swap) begin
            rd_mask <= wr_mask_set;
            wr_mask <= '0;
        end else if (drop) begin
            wr_mask <= '0;
        end else begin
            wr_mask <= wr_mask_set;
        end
    end

    assign data_d = rd_mask[rd_idx] ? rd_word : '0;
`else
    assign data_d = rd_word;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next output values of the replay side.
    always_comb begin
        state_d   = state;
        valid_d   = out_valid;
        idx_d     = out_idx;
        last_d    = out_last;
        load_data = 1'b0;
        rd_idx    = '0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d   = S_STREAM;
                valid_d   = 1'b1;
                idx_d     = '0;
                last_d    = 1'b0;
                rd_idx    = '0;
                load_data = 1'b1;
            end
            S_STREAM: begin
                if (beat) begin
                    if (out_idx == LAST_IDX) begin
                        state_d = swap ? S_LOAD : S_IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d     = out_idx + ADDR_W'(1);
                        rd_idx    = idx_d;
                        last_d    = (idx_d == LAST_IDX);
                        load_data = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbank     <= 1'b0;
            pending   <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            // A swap seen in IDLE waits one cycle before LOAD; a swap on the final beat goes straight to LOAD.
            pending   <= swap && (state == S_IDLE);
            if (swap) begin
                wbank <= ~wbank;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            out_valid <= valid_d;
            out_idx   <= idx_d;
            out_last  <= last_d;
            if (load_data) begin
                out_data <= data_d;
            end
        end
    end

endmodule

// File: tb/tb_raise_frame_buffer.sv
// Scoreboard bench for raise_frame_buffer: a bank model predicts every replayed beat at frame end.
module tb_raise_frame_buffer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [ADDR_W-1:0] in_freq;
    logic              in_fin;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    beat_t             sb[$];
    logic [DATA_W-1:0] shadow [2][DEPTH];
    logic [DEPTH-1:0]  mask [2];
    int                m_wbank = 0;

    raise_frame_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_freq   (in_freq),
        .in_fin    (in_fin),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every presented beat (stalled or accepted) must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got idx=%0d data=%h, expected no beat", out_idx, out_data);
            end else begin
                if (out_idx !== sb[0].idx || out_data !== sb[0].data || out_last !== sb[0].last) begin
                    errors++;
                    $display("FAIL beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                             out_idx, out_data, out_last, sb[0].idx, sb[0].data, sb[0].last);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DATA_W-1:0] frame_word(input int k, input int seed);
        return DATA_W'(32'h0001_0001 * k + 32'h0100_0100 * seed);
    endfunction

    task automatic model_frame_end(input bit expect_swap);
        beat_t b;
        if (expect_swap) begin
            for (int k = 0; k < DEPTH; k++) begin
                b.idx = ADDR_W'(k);
`ifdef RAISE_FRAME_ZERO_FILL_EN
                b.data = mask[m_wbank][k] ? shadow[m_wbank][k] : '0;
`else
                b.data = shadow[m_wbank][k];
`endif
                b.last = (k == DEPTH - 1);
                sb.push_back(b);
            end
            m_wbank ^= 1;
            mask[m_wbank] = '0;
        end else begin
            mask[m_wbank] = '0;
        end
    endtask

    task automatic send_bin(input int freq, input logic [DATA_W-1:0] data, input bit fin, input bit expect_swap);
        in_valid = 1'b1;
        in_freq  = ADDR_W'(freq);
        in_data  = data;
        in_fin   = fin;
        shadow[m_wbank][freq] = data;
        mask[m_wbank][freq]   = 1'b1;
        if (fin) model_frame_end(expect_swap);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_fin   = 1'b0;
    endtask

    task automatic send_frame(input int nbins, input int seed, input bit expect_swap);
        for (int k = 0; k < nbins; k++) begin
            send_bin(k, frame_word(k, seed), (k == nbins - 1), expect_swap);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_wbank = 0;
        mask[0] = '0;
        mask[1] = '0;
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_fin   = 1'b0;
        model_reset();
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_fin    = 1'b0;
        in_freq   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, expected 0", out_last); end
        if (out_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d, expected 0", out_idx); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h, expected 0", out_data); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        out_ready = 1'b1;
        send_frame(DEPTH, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_fin_edge: got valid=%b, expected 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_load: got valid=%b, expected 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_stream: got valid=%b, expected 1", out_valid); end
        wait_drain("single_frame", 200);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b, expected 0", overflow); end
    endtask

    task automatic test_back_pressure();
        logic [3:0] pat;
        int c;
        pat = 4'b1001;
        out_ready = 1'b0;
        send_frame(DEPTH, 1, 1'b1);
        c = 0;
        while (sb.size() != 0 && c < 400) begin
            out_ready = pat[c % 4];
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL backpressure_drain: %0d beats left, expected 0", sb.size()); end
        out_ready = 1'b1;
    endtask

    task automatic test_overflow();
        fork
            begin
                send_frame(DEPTH, 2, 1'b1);
                send_frame(DEPTH, 9, 1'b0);
            end
            begin
                out_ready = 1'b0;
                repeat (70) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, expected 1", overflow); end
        wait_drain("overflow", 200);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL dropped_frame_streamed: got valid=%b, expected 0", out_valid); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b, expected 1", overflow); end
    endtask

    task automatic test_coincident();
        apply_reset();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared: got %b, expected 0", overflow); end
        out_ready = 1'b1;
        send_frame(DEPTH, 3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        send_frame(DEPTH, 4, 1'b1);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL coincident_load: got valid=%b, expected 0", out_valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL coincident_overflow: got %b, expected 0", overflow); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== '0) begin
            errors++;
            $display("FAIL coincident_restart: got valid=%b idx=%0d, expected valid=1 idx=0", out_valid, out_idx);
        end
        wait_drain("coincident", 200);
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_frame(DEPTH, 5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_idx !== ADDR_W'(10)) begin errors++; $display("FAIL midreset_setup_idx: got %0d, expected 10", out_idx); end
        for (int k = 0; k < 30; k++) send_bin(k, frame_word(k, 6), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_freq  = ADDR_W'(30);
        in_data  = frame_word(30, 6);
        #2;
        rst = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, expected 0", out_valid); end
        if (out_idx !== '0) begin errors++; $display("FAIL midreset_idx: got %0d, expected 0", out_idx); end
        if (out_data !== '0) begin errors++; $display("FAIL midreset_data: got %h, expected 0", out_data); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL midreset_last: got %b, expected 0", out_last); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow: got %b, expected 0", overflow); end
        in_valid = 1'b0;
        model_reset();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_frame(DEPTH, 7, 1'b1);
        wait_drain("post_reset", 200);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL post_reset_overflow: got %b, expected 0", overflow); end
    endtask

    task automatic test_partial_frame();
        out_ready = 1'b1;
        send_frame(32, 8, 1'b1);
        wait_drain("partial", 200);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_overflow();
        test_coincident();
        test_reset_mid_frame();
        test_partial_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/raise_frame_buffer.md
Name: raise_frame_buffer

Overview:
- Ping-pong frame buffer directly downstream of raiseFreq.
- Captures the frequency-shifted spectrum stream (raise_data / raise_valid / freq_out / raise_fin) into one 64-bin bank.
- On frame end, swaps banks and replays the completed frame in natural bin order (0..63) over a valid/ready stream to the inverse-FFT stage.
- Decouples raiseFreq's fixed-rate push from IFFT back-pressure.

Parameters:
- DATA_W, 32, bin word width ({re[31:16], im[15:0]}, passed through untouched).
- ADDR_W, 6, bin index width.
- DEPTH, 64, bins per frame (must equal 2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  bin value from raiseFreq (raise_data).
- in_valid  input  1  in_data/in_freq valid this cycle (raise_valid).
- in_freq  input  ADDR_W  bin index of in_data (freq_out).
- in_fin  input  1  frame end; coincides with the last bin of the frame (raise_fin).
- out_data  output  DATA_W  bin value to IFFT.
- out_idx  output  ADDR_W  bin index of out_data.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  IFFT accepts the beat when out_valid && out_ready.
- out_last  output  1  high with the beat where out_idx == DEPTH-1.
- overflow  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (rst low, async):
  - out_valid=0, out_last=0, out_idx=0, out_data=0, overflow=0.
  - Write bank = 0; read bank empty; read FSM = IDLE.
  - Memory contents are not reset.
- Write side:
  - Each cycle with in_valid=1: mem[wbank][in_freq] <= in_data. Bins may arrive in any order; a repeated index overwrites.
  - in_fin is sampled only when in_valid=1; in_fin with in_valid=0 is ignored.
- Frame completion (in_valid && in_fin), evaluated after the same-cycle write:
  - If the read bank is free (IDLE, or STREAM consuming its final beat this cycle): wbank toggles and the completed bank becomes the read bank.
  - Otherwise the frame is dropped: wbank is unchanged (next frame overwrites it) and overflow <= 1.
  - overflow stays set until reset.
- Read FSM:
  - IDLE -> LOAD on a swap.
  - LOAD: one cycle for registered memory read of bin 0.
  - LOAD -> STREAM: out_valid=1, out_idx=0.
  - STREAM: on out_valid && out_ready, out_idx increments and out_data updates to the next bin; registered, so the next beat is presented in the following cycle with no bubble.
  - While out_valid && !out_ready, out_data/out_idx/out_last hold stable.
  - After the beat with out_idx=DEPTH-1 is accepted: if a swap occurs the same cycle -> LOAD, else -> IDLE. out_valid drops, out_idx returns to 0.
- Latency:
  - Frame-end edge N: swap.
  - Edge N+1: LOAD.
  - Edge N+2: out_valid=1, bin 0.
  - With out_ready tied high, 64 beats on consecutive cycles.
- Simultaneous write and read never touch the same bank; no bypass is needed.
- out_idx wraps only through the FSM, never arithmetically past DEPTH-1.
- Reset mid-frame discards both banks' status. Any partially written frame is abandoned; the first post-reset frame starts fresh in bank 0.

Optional Feature:
- Macro: RAISE_FRAME_ZERO_FILL_EN.
- Defined:
  - A DEPTH-bit written mask is kept per bank, set on each write.
  - On swap, the outgoing read bank's mask is latched and the new write bank's mask is cleared.
  - During STREAM, bins whose mask bit is 0 output out_data=0.
  - A dropped frame also clears its mask.
- Undefined:
  - No masks; unwritten bins replay whatever the bank last held (stale data).
  - Port list is identical in both builds.

Test Plan:
- Reset release, one frame bins 0..63 with data=0x00010000*k + k, in_fin with bin 63, out_ready=1 -> out_valid rises 2 cycles after the fin edge; 64 beats out_idx 0..63 with matching data; out_last only at idx 63; overflow=0.
- Back-pressure: out_ready toggled 1,0,0,1 repeating -> every beat accepted exactly once, in order; data/idx stable during stalls.
- Two frames back-to-back at full input rate, out_ready=0 for the first 70 cycles -> second frame's fin finds read bank busy; overflow=1; after releasing out_ready, only frame 1 is output.
- Frame end coincident with the final accepted beat of the previous frame -> no overflow; next frame starts with LOAD the following cycle.
- Reset asserted at bin 30 of a frame while streaming idx 10 -> outputs zero immediately (async); the next full frame streams correctly from bank 0.
- With RAISE_FRAME_ZERO_FILL_EN, frame writes only bins 0..31 plus fin at bin 31 -> out bins 32..63 are 0x00000000. Without it, they carry the previous frame's values.
